// File: rtl/zxuno_pkg.sv
// Shared constants, state encoding and captured-bus type for the ZX-UNO
// extended register port front end.
package zxuno_pkg;

  localparam logic [15:0] ZXUNO_ADDR_PORT  = 16'hFC3B;
  localparam logic [15:0] ZXUNO_DATA_PORT  = 16'hFD3B;
  localparam logic [7:0]  ZXUNO_RD_DEFAULT = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_AWR     = 3'd1,
    ST_DRD     = 3'd2,
    ST_DWR     = 3'd3,
    ST_WAITEND = 3'd4
  } zx_state_t;

  // One registered snapshot of the CPU bus.
  typedef struct packed {
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic [15:0] a;
    logic [7:0]  din;
  } cpu_req_t;

endpackage

// File: rtl/zxuno_rdmux.sv
// Priority readback mux: lowest-index enabled slave wins; flags any/multiple
// enables so the controller can register data and conflict status.
module zxuno_rdmux
  import zxuno_pkg::*;
#(
  parameter int NSLAVES = 4
) (
  input  logic [NSLAVES-1:0][7:0] slv_dout,
  input  logic [NSLAVES-1:0]      slv_oe_n,
  output logic [7:0]              sel_dout,
  output logic                    any_oe,
  output logic                    multi_oe
);

  // Scan high to low so the last hit, i.e. the lowest index, drives the data.
  always_comb begin
    sel_dout = ZXUNO_RD_DEFAULT;
    any_oe   = 1'b0;
    multi_oe = 1'b0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if (!slv_oe_n[i]) begin
        if (any_oe) multi_oe = 1'b1;
        any_oe   = 1'b1;
        sel_dout = slv_dout[i];
      end
    end
  end

endmodule

// File: rtl/zxuno_regport_ctrl.sv
// ZX-UNO register port controller: decodes address/data port cycles, holds the
// register address, strobes the slaves and returns muxed read data.
module zxuno_regport_ctrl
  import zxuno_pkg::*;
#(
  parameter int          NSLAVES    = 4,
  parameter logic [15:0] ADDR_PORT  = ZXUNO_ADDR_PORT,
  parameter logic [15:0] DATA_PORT  = ZXUNO_DATA_PORT,
  parameter logic [7:0]  RESET_ADDR = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            a,
  input  logic                   iorq_n,
  input  logic                   rd_n,
  input  logic                   wr_n,
  input  logic [7:0]             din,
  output logic [7:0]             zxuno_addr,
  output logic                   regaddr_changed,
  output logic                   zxuno_regrd,
  output logic                   zxuno_regwr,
  output logic [7:0]             regwr_data,
  input  logic [8*NSLAVES-1:0]   slv_dout,
  input  logic [NSLAVES-1:0]     slv_oe_n,
  output logic [7:0]             cpu_dout,
  output logic                   cpu_oe_n,
  output logic                   bus_conflict
);

  cpu_req_t  req_q;
  zx_state_t state, state_nx;

  logic rdacc, wracc, hit_addr, hit_data, cyc_end;
  logic idle, go_awr_w, go_awr_r, go_dwr, go_drd, in_drd;
  logic aread_q, conf_seen;
  logic [7:0] sel_dout;
  logic any_oe, multi_oe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_q <= '{iorq_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, a: 16'h0, din: 8'h0};
    else        req_q <= '{iorq_n: iorq_n, rd_n: rd_n, wr_n: wr_n, a: a, din: din};
  end

  // Both strobes low qualifies as neither access.
  assign rdacc    = !req_q.iorq_n && !req_q.rd_n && req_q.wr_n;
  assign wracc    = !req_q.iorq_n && !req_q.wr_n && req_q.rd_n;
  assign hit_addr = (req_q.a == ADDR_PORT);
  assign hit_data = (req_q.a == DATA_PORT);
  assign cyc_end  = req_q.iorq_n || (req_q.rd_n && req_q.wr_n);

  assign idle     = (state == ST_IDLE);
  assign go_awr_w = idle && wracc && hit_addr;
  assign go_dwr   = idle && wracc && hit_data;
  assign go_awr_r = idle && rdacc && hit_addr;
  assign go_drd   = idle && rdacc && hit_data;
  assign in_drd   = (state == ST_DRD) && rdacc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (go_awr_w || go_awr_r) state_nx = ST_AWR;
        else if (go_dwr)          state_nx = ST_DWR;
        else if (go_drd)          state_nx = ST_DRD;
      end
      ST_AWR, ST_DWR: state_nx = ST_WAITEND;
      ST_DRD:         if (!rdacc) state_nx = ST_IDLE;
      ST_WAITEND:     if (cyc_end) state_nx = ST_IDLE;
      default:        state_nx = ST_IDLE;
    endcase
  end

  zxuno_rdmux #(.NSLAVES(NSLAVES)) u_rdmux (
    .slv_dout (slv_dout),
    .slv_oe_n (slv_oe_n),
    .sel_dout (sel_dout),
    .any_oe   (any_oe),
    .multi_oe (multi_oe)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zxuno_addr      <= RESET_ADDR;
      regwr_data      <= 8'h00;
      cpu_dout        <= ZXUNO_RD_DEFAULT;
      regaddr_changed <= 1'b0;
      zxuno_regwr     <= 1'b0;
      bus_conflict    <= 1'b0;
      aread_q         <= 1'b0;
      conf_seen       <= 1'b0;
    end else begin
      regaddr_changed <= go_awr_w;
      zxuno_regwr     <= go_dwr;
      bus_conflict    <= 1'b0;
      if (go_awr_w) zxuno_addr <= req_q.din;
      if (go_dwr)   regwr_data <= req_q.din;
      if (go_awr_r) begin
        cpu_dout <= zxuno_addr;
      end else if (in_drd) begin
        cpu_dout <= any_oe ? sel_dout : ZXUNO_RD_DEFAULT;
        // Report a contended read only once per data-port access.
        if (multi_oe && !conf_seen) begin
          bus_conflict <= 1'b1;
          conf_seen    <= 1'b1;
        end
      end
      if (go_drd) conf_seen <= 1'b0;
      if (go_awr_r)                   aread_q <= 1'b1;
      else if (state_nx == ST_IDLE)   aread_q <= 1'b0;
    end
  end

  // Bus enable follows the registered strobes directly so it releases as soon
  // as the CPU ends the cycle.
  assign zxuno_regrd = in_drd;
  assign cpu_oe_n    = !(in_drd || (aread_q && rdacc));

endmodule

// File: doc/zxuno_regport_ctrl.md
Name: zxuno_regport_ctrl

Overview:
- Front end of the ZX-UNO extended register space.
- Decodes CPU I/O cycles to the address port and the data port, and holds the current register address.
- Drives read/write strobes and the address-change pulse to all register slaves (core ID, config, etc.).
- Priority-multiplexes slave read data back to the CPU data bus.

Parameters:
- NSLAVES, 4, number of register slaves on the readback mux.
- ADDR_PORT, 16'hFC3B, I/O address of the register-address port.
- DATA_PORT, 16'hFD3B, I/O address of the register-data port.
- RESET_ADDR, 8'h00, zxuno_addr value after reset.

Ports:
- clk  in  1  system clock; all CPU inputs are synchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- a  in  16  CPU address bus.
- iorq_n  in  1  CPU I/O request, active low.
- rd_n  in  1  CPU read strobe, active low.
- wr_n  in  1  CPU write strobe, active low.
- din  in  8  CPU write data.
- zxuno_addr  out  8  current register address.
- regaddr_changed  out  1  one-cycle pulse when the address port is written.
- zxuno_regrd  out  1  high for the duration of a data-port read.
- zxuno_regwr  out  1  one-cycle pulse on a data-port write.
- regwr_data  out  8  data latched on a data-port write; valid when zxuno_regwr=1 and held afterwards.
- slv_dout  in  8*NSLAVES  slave read data, slave i on bits [8i+7:8i].
- slv_oe_n  in  NSLAVES  slave output enables, active low.
- cpu_dout  out  8  read data to the CPU.
- cpu_oe_n  out  1  drives cpu_dout onto the CPU bus, active low.
- bus_conflict  out  1  one-cycle pulse when more than one slave asserts oe_n during a data read.

Behaviour:
- Reset (asynchronous, immediate, also mid-cycle):
  - zxuno_addr=RESET_ADDR, regwr_data=00, cpu_dout=FF.
  - regaddr_changed=0, zxuno_regwr=0, zxuno_regrd=0, bus_conflict=0, cpu_oe_n=1.
  - State IDLE.
- Input capture: iorq_n, rd_n, wr_n, a and din are registered in one stage. All decode uses the registered copies.
- Access qualifiers:
  - rdacc = !iorq_n & !rd_n & wr_n.
  - wracc = !iorq_n & !wr_n & rd_n.
  - rd_n and wr_n both low is invalid: no action, state unchanged.
- FSM states: IDLE, AWR, DRD, DWR, WAITEND.
  - IDLE, wracc with a==ADDR_PORT -> AWR. On that edge: zxuno_addr<=din, regaddr_changed=1 for one cycle. The pulse fires even if the value is unchanged.
  - IDLE, wracc with a==DATA_PORT -> DWR. On that edge: regwr_data<=din, zxuno_regwr=1 for one cycle.
  - IDLE, rdacc with a==ADDR_PORT -> AWR. cpu_dout<=zxuno_addr, cpu_oe_n=0.
  - IDLE, rdacc with a==DATA_PORT -> DRD. zxuno_regrd=1 from the entry cycle.
  - IDLE, any other address: stay IDLE, outputs idle.
  - AWR and DWR -> WAITEND on the next clock. Pulses are exactly one clock wide.
  - DRD: zxuno_regrd stays 1 and cpu_oe_n stays 0 while rdacc holds. When rdacc drops, go to IDLE with zxuno_regrd=0 and cpu_oe_n=1 in that same cycle.
  - WAITEND -> IDLE once iorq_n=1 or both strobes are high.
  - Address-port read: cpu_oe_n is released in the same cycle iorq_n rises.
  - One access produces exactly one strobe, however long the CPU holds the cycle.
- Readback in DRD, registered with 1-cycle latency after slave oe_n:
  - cpu_dout = slv_dout of the lowest-index slave with slv_oe_n=0.
  - If no slave is enabled, cpu_dout=FF; cpu_oe_n still stays 0 so that unmapped registers read FF.
  - If two or more slaves are enabled: bus_conflict pulses once per DRD entry, and the lowest index wins.
- Back-to-back accesses:
  - A new access is only recognised from IDLE.
  - A back-to-back write to the address port then a read of the data port therefore produces regaddr_changed, then regrd on a later, distinct cycle.
- zxuno_addr changes only on address-port writes and reset.

Decomposition:
- Package zxuno_pkg holds:
  - default port constants ZXUNO_ADDR_PORT and ZXUNO_DATA_PORT;
  - the FSM state encoding (3-bit, IDLE=0);
  - the read default 8'hFF.
- One sub-module, zxuno_rdmux: combinational priority encoder and mux over NSLAVES. Outputs sel_dout, any_oe and multi_oe; the controller registers them.

Test Plan:
- Reset, then assert rst_n. Expected: zxuno_addr=00, cpu_oe_n=1, cpu_dout=FF, all strobes 0. Assert rst_n low mid-DRD: regrd drops in the same cycle.
- Write FF to FC3B, holding iorq_n low 6 clocks. Expected: zxuno_addr=FF, regaddr_changed high exactly 1 clock, 2 cycles after the cycle start; no regwr.
- With addr=FF and a core-ID slave model on slot 0, do three data-port reads. Expected: zxuno_regrd high for each full read, cpu_dout='T','2','4' in turn; a rewrite of FF to FC3B restarts at 'T'.
- Write 5A to FD3B. Expected: zxuno_regwr one pulse with regwr_data=5A; a 10-clock hold still gives one pulse only.
- Read FD3B with slots 1 and 3 both enabled (data 11 and 33). Expected: cpu_dout=11, bus_conflict one pulse. With no slave enabled: cpu_dout=FF, cpu_oe_n=0.
- Assert rd_n and wr_n low together at FD3B, then access an unrelated port 00FE. Expected: no strobes and cpu_oe_n=1 throughout. A read of FC3B then returns the current zxuno_addr.
